// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor.
//   state_e  : supervisor FSM states
//   RETRY_W  : width of the retry_count port
//   LOSS_SAT : saturation value of lock_loss_count
//   cw()     : counter width helper, never returns less than 1
package pll_sup_pkg;

  typedef enum logic [2:0] {
    HOLD,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAIL
  } state_e;

  localparam int         RETRY_W  = 4;
  localparam logic [7:0] LOSS_SAT = 8'd255;

  // A bound of 1 still needs a 1-bit counter.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync.sv
// Single-bit multi-flop synchronizer with asynchronous reset to 0.
//   i_clk  : destination clock
//   i_rst  : async active-high reset
//   i_d    : asynchronous input
//   o_q    : synchronized output (last stage)
module pll_sup_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_sync <= '0;
    else       r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: drives the PLL reset, qualifies its locked output and
// produces a system reset released only after lock has been stable.
//   refclk          : reference clock, all logic on rising edge
//   rst             : async active-high reset
//   pll_locked      : raw PLL locked (async, may glitch)
//   relock_req      : one-cycle pulse, restarts the reset/lock sequence
//   pll_rst         : PLL reset output
//   sys_reset       : system reset request (low only in RUN)
//   ready           : high in RUN
//   pll_fail        : high in FAIL
//   retry_count     : retries used in the current acquisition
//   lock_loss_count : lock losses seen in RUN, saturating
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_HOLD_CYCLES = 16,
  parameter int LOCK_TIMEOUT    = 262144,
  parameter int STABLE_CYCLES   = 4096,
  parameter int MAX_RETRIES     = 7,
  parameter int SYNC_STAGES     = 2
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               relock_req,
  output logic               pll_rst,
  output logic               sys_reset,
  output logic               ready,
  output logic               pll_fail,
  output logic [RETRY_W-1:0] retry_count,
  output logic [7:0]         lock_loss_count
);

  localparam int HW = cw(RST_HOLD_CYCLES);
  localparam int AW = cw(LOCK_TIMEOUT);
  localparam int SW = cw(STABLE_CYCLES);

  localparam logic [HW-1:0]      HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);
  localparam logic [AW-1:0]      ACQ_LAST  = AW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0]      STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  state_e              r_state, w_state_nxt;
  logic [HW-1:0]       r_hold_cnt, w_hold_nxt;
  logic [AW-1:0]       r_acq_cnt, w_acq_nxt;
  logic [SW-1:0]       r_stab_cnt, w_stab_nxt;
  logic [RETRY_W-1:0]  w_retry_nxt;
  logic [7:0]          w_loss_nxt;
  logic                w_locked_s;
  logic                w_timeout;

  pll_sup_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .i_clk (refclk),
    .i_rst (rst),
    .i_d   (pll_locked),
    .o_q   (w_locked_s)
  );

  assign w_timeout = (r_acq_cnt == ACQ_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_acq_nxt   = r_acq_cnt;
    w_stab_nxt  = r_stab_cnt;
    w_retry_nxt = retry_count;
    w_loss_nxt  = lock_loss_count;

    if (relock_req) begin
      // Beats every other transition, including entering RUN.
      w_state_nxt = HOLD;
      w_hold_nxt  = '0;
      w_retry_nxt = '0;
    end else begin
      case (r_state)
        HOLD: begin
          if (r_hold_cnt == HOLD_LAST) begin
            w_state_nxt = WAIT_LOCK;
            w_acq_nxt   = '0;
          end else begin
            w_hold_nxt = r_hold_cnt + 1'b1;
          end
        end
        WAIT_LOCK, STABLE: begin
          // acq_cnt stops at its last value so it never wraps.
          if (!w_timeout) w_acq_nxt = r_acq_cnt + 1'b1;
          if (r_state == STABLE && w_locked_s && r_stab_cnt == STAB_LAST) begin
            w_state_nxt = RUN;
          end else if (w_timeout) begin
            if (retry_count == RETRY_MAX) begin
              w_state_nxt = FAIL;
            end else begin
              w_state_nxt = HOLD;
              w_hold_nxt  = '0;
              w_retry_nxt = retry_count + 1'b1;
            end
          end else if (w_locked_s) begin
            w_state_nxt = STABLE;
            w_stab_nxt  = (r_state == STABLE) ? r_stab_cnt + 1'b1 : '0;
          end else begin
            // Lock dropped while qualifying: acq_cnt keeps running so
            // persistent chatter still ends in a timeout.
            w_state_nxt = WAIT_LOCK;
            w_stab_nxt  = '0;
          end
        end
        RUN: begin
          if (!w_locked_s) begin
            w_state_nxt = HOLD;
            w_hold_nxt  = '0;
            w_retry_nxt = '0;
            w_loss_nxt  = (lock_loss_count == LOSS_SAT) ? LOSS_SAT
                                                       : lock_loss_count + 8'd1;
          end
        end
        FAIL: ;
        default: begin
          w_state_nxt = HOLD;
          w_hold_nxt  = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the transition.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_state         <= HOLD;
      r_hold_cnt      <= '0;
      r_acq_cnt       <= '0;
      r_stab_cnt      <= '0;
      retry_count     <= '0;
      lock_loss_count <= '0;
      pll_rst         <= 1'b1;
      sys_reset       <= 1'b1;
      ready           <= 1'b0;
      pll_fail        <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_hold_cnt      <= w_hold_nxt;
      r_acq_cnt       <= w_acq_nxt;
      r_stab_cnt      <= w_stab_nxt;
      retry_count     <= w_retry_nxt;
      lock_loss_count <= w_loss_nxt;
      pll_rst         <= (w_state_nxt == HOLD) || (w_state_nxt == FAIL);
      sys_reset       <= (w_state_nxt != RUN);
      ready           <= (w_state_nxt == RUN);
      pll_fail        <= (w_state_nxt == FAIL);
    end
  end

endmodule
